cache_arbiter: RTL and testbench

Round-robin Wishbone B4 arbiter that shares the accelerator's single 256-bit cache port between N internal requesters, such as the weight fetcher, the feature-map loader and the result writer. It sits between those engines and the `cache_*` port of the accelerator top level. A grant is held for a requester's whole `cyc` tenure, so registered bursts (`cti`/`bte`) pass through intact. A per-grant watchdog returns an error and frees the port if the cache stops acknowledging.

---
 rtl/cache_arbiter.sv | 158 +++++++++++++++
 tb/tb_cache_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin Wishbone arbiter sharing one cache port among N requesters; grant held for a whole cyc tenure.
// 1-cycle arbitration, combinational forwarding in GRANT; a per-grant watchdog errors out and frees a stalled port.
module cache_arbiter #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              m_cyc_i,
  input  logic [N-1:0]              m_stb_i,
  input  logic [N-1:0]              m_we_i,
  input  logic [N*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [N*DATA_WIDTH-1:0]   m_mosi_i,
  input  logic [N*3-1:0]            m_cti_i,
  input  logic [N*2-1:0]            m_bte_i,
  output logic [N-1:0]              m_ack_o,
  output logic [N-1:0]              m_err_o,
  output logic [DATA_WIDTH-1:0]     m_miso_o,
  output logic [N-1:0]              grant_o,
  output logic                      cache_cyc_o,
  output logic                      cache_stb_o,
  output logic                      cache_we_o,
  output logic [ADDR_WIDTH-1:0]     cache_addr_o,
  output logic [DATA_WIDTH-1:0]     cache_mosi_o,
  output logic [2:0]                cache_cti_o,
  output logic [1:0]                cache_bte_o,
  input  logic                      cache_ack_i,
  input  logic [DATA_WIDTH-1:0]     cache_miso_i
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                r_state, w_state_nxt;
  logic [N-1:0]          r_grant, w_grant_nxt;
  logic [N-1:0]          r_blocked, w_blocked_nxt;
  logic [LW-1:0]         r_last, w_last_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;

  logic [N-1:0]          w_elig;
  logic                  w_found;
  logic [LW-1:0]         w_pick;
  logic                  w_timeout;

  logic                  w_cyc, w_stb, w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_mosi;
  logic [2:0]            w_cti;
  logic [1:0]            w_bte;

  assign w_elig = m_cyc_i & ~r_blocked;

  // Cyclic search starting just after the last owner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && w_elig[i] && (((int'(r_last) + k) % N) == i)) begin
          w_found = 1'b1;
          w_pick  = LW'(i);
        end
      end
    end
  end

  // One-hot AND-OR mux; r_grant is zero outside GRANT so the bus idles at 0.
  always_comb begin
    w_cyc  = 1'b0;
    w_stb  = 1'b0;
    w_we   = 1'b0;
    w_addr = '0;
    w_mosi = '0;
    w_cti  = '0;
    w_bte  = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_cyc  = m_cyc_i[i];
        w_stb  = m_stb_i[i];
        w_we   = m_we_i[i];
        w_addr = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_mosi = m_mosi_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_cti  = m_cti_i[i*3 +: 3];
        w_bte  = m_bte_i[i*2 +: 2];
      end
    end
  end

  // An ack on the threshold cycle wins over the timeout.
  assign w_timeout = (TIMEOUT != 0) && (r_state == S_GRANT) && w_cyc && w_stb &&
                     !cache_ack_i && (r_cnt == CW'(TIMEOUT));

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_cnt_nxt     = '0;
    w_blocked_nxt = r_blocked & m_cyc_i;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = N'(1) << w_pick;
          w_last_nxt  = w_pick;
        end
      end
      S_GRANT: begin
        if (!w_cyc) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end else if (w_timeout) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = '0;
          w_blocked_nxt = w_blocked_nxt | r_grant;
        end else if (w_stb && !cache_ack_i && (TIMEOUT != 0)) begin
          w_cnt_nxt = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_last    <= LW'(N - 1);
      r_blocked <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_blocked <= w_blocked_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign grant_o      = r_grant;
  assign m_ack_o      = r_grant & {N{cache_ack_i}};
  assign m_err_o      = r_grant & {N{w_timeout}};
  assign m_miso_o     = rst_n ? cache_miso_i : '0;
  assign cache_cyc_o  = w_cyc;
  assign cache_stb_o  = w_stb;
  assign cache_we_o   = w_we;
  assign cache_addr_o = w_addr;
  assign cache_mosi_o = w_mosi;
  assign cache_cti_o  = w_cti;
  assign cache_bte_o  = w_bte;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected grants/beats/errors with cycle stamps, a negedge monitor pops and compares.
module tb_cache_arbiter;

  localparam int N  = 3;
  localparam int DW = 256;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_mosi;
  logic [N*3-1:0] m_cti;
  logic [N*2-1:0] m_bte;
  logic [N-1:0]   m_ack_o, m_err_o, grant_o;
  logic [DW-1:0]  m_miso_o;
  logic           cache_cyc_o, cache_stb_o, cache_we_o;
  logic [AW-1:0]  cache_addr_o;
  logic [DW-1:0]  cache_mosi_o;
  logic [2:0]     cache_cti_o;
  logic [1:0]     cache_bte_o;
  logic           cache_ack;
  logic [DW-1:0]  cache_miso;

  cache_arbiter #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_mosi_i(m_mosi), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_miso_o(m_miso_o), .grant_o(grant_o),
    .cache_cyc_o(cache_cyc_o), .cache_stb_o(cache_stb_o), .cache_we_o(cache_we_o),
    .cache_addr_o(cache_addr_o), .cache_mosi_o(cache_mosi_o),
    .cache_cti_o(cache_cti_o), .cache_bte_o(cache_bte_o),
    .cache_ack_i(cache_ack), .cache_miso_i(cache_miso)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct { int cyc; logic [N-1:0] val; } ev_t;
  typedef struct {
    int cyc; logic [N-1:0] ack; logic we; logic [AW-1:0] addr;
    logic [2:0] cti; logic [1:0] bte; logic [DW-1:0] mosi; logic [DW-1:0] miso;
  } beat_t;

  ev_t   q_grant[$];
  ev_t   q_err[$];
  beat_t q_beat[$];

  int n_checks = 0;
  int n_pass   = 0;
  int nbeat    = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int r, input logic on);
    m_cyc[r] = on;
    m_stb[r] = on;
  endtask

  task automatic exp_grant(input int r, input int c);
    ev_t e;
    e.cyc = c;
    e.val = N'(1) << r;
    q_grant.push_back(e);
  endtask

  // Cache acknowledges one beat of requester r in the current cycle.
  task automatic beat(input int r, input logic [AW-1:0] a, input logic [2:0] cti);
    beat_t b;
    m_addr[r*AW +: AW] = a;
    m_cti[r*3 +: 3]    = cti;
    cache_miso         = {8{32'hC0DE_0000 + 32'(nbeat)}};
    nbeat++;
    cache_ack = 1'b1;
    b.cyc  = cyc_n;
    b.ack  = N'(1) << r;
    b.we   = m_we[r];
    b.addr = a;
    b.cti  = cti;
    b.bte  = m_bte[r*2 +: 2];
    b.mosi = m_mosi[r*DW +: DW];
    b.miso = cache_miso;
    q_beat.push_back(b);
    tick();
    cache_ack = 1'b0;
  endtask

  task automatic drop(input int r);
    req(r, 1'b0);
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {cache_cyc_o, cache_stb_o, cache_we_o, cache_addr_o, cache_cti_o,
                        cache_bte_o, m_ack_o, m_err_o, grant_o}, '0);
    chk({tag, "_data"}, {cache_mosi_o, m_miso_o}, '0);
  endtask

  // Monitor
  initial begin
    logic [N-1:0] prev;
    ev_t   e;
    beat_t b;
    prev = '0;
    forever begin
      @(negedge clk);
      if (grant_o != '0 && grant_o != prev) begin
        if (q_grant.size() == 0) chk("unexpected_grant", grant_o, '0);
        else begin
          e = q_grant.pop_front();
          chk("grant", {cyc_n, grant_o}, {e.cyc, e.val});
        end
      end
      prev = grant_o;
      if (grant_o == '0)
        chk("idle_bus", {cache_cyc_o, cache_stb_o, cache_we_o, cache_addr_o, cache_mosi_o,
                         cache_cti_o, cache_bte_o, m_ack_o}, '0);
      if (m_ack_o != '0) begin
        if (q_beat.size() == 0) chk("unexpected_ack", m_ack_o, '0);
        else begin
          b = q_beat.pop_front();
          chk("beat_ctl", {cyc_n, m_ack_o, cache_cyc_o, cache_stb_o, cache_we_o,
                           cache_addr_o, cache_cti_o, cache_bte_o},
                          {b.cyc, b.ack, 1'b1, 1'b1, b.we, b.addr, b.cti, b.bte});
          chk("beat_data", {cache_mosi_o, m_miso_o}, {b.mosi, b.miso});
        end
      end
      if (m_err_o != '0) begin
        if (q_err.size() == 0) chk("unexpected_err", m_err_o, '0);
        else begin
          e = q_err.pop_front();
          chk("err", {cyc_n, m_err_o}, {e.cyc, e.val});
        end
      end
    end
  end

  // Stimulus
  initial begin
    int t;
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0; m_bte = '0;
    cache_ack = 1'b0;
    cache_miso = '1;
    for (int r = 0; r < N; r++) begin
      m_addr[r*AW +: AW] = 32'h1000 * 32'(r + 1);
      m_mosi[r*DW +: DW] = {8{32'hD0D0_0000 + 32'(r)}};
    end
    req(0, 1'b1); req(1, 1'b1); req(2, 1'b1);
    tick(); tick();
    chk_reset("reset_state");

    // Reset priority: 0, 1, 2 with one idle cycle between owners
    tick();
    rst_n = 1'b1;
    exp_grant(0, cyc_n + 1); tick();
    beat(0, 32'h1000, 3'b000); drop(0);
    exp_grant(1, cyc_n + 1); tick();
    beat(1, 32'h2000, 3'b000); drop(1);
    exp_grant(2, cyc_n + 1); tick();
    beat(2, 32'h3000, 3'b000); drop(2);

    // Fairness: 0 re-requests at once, 1 keeps waiting -> 0,1,0,1
    req(0, 1'b1); req(1, 1'b1);
    exp_grant(0, cyc_n + 1); tick();
    for (int i = 0; i < 2; i++) begin
      beat(0, 32'h1010, 3'b000); drop(0);
      if (i == 0) req(0, 1'b1);
      exp_grant(1, cyc_n + 1); tick();
      beat(1, 32'h2010, 3'b000); drop(1);
      if (i == 0) begin
        req(1, 1'b1);
        exp_grant(0, cyc_n + 1); tick();
      end
    end

    // Burst pass-through on requester 2 with 0 and 1 arriving mid-burst
    m_we[2] = 1'b1;
    req(2, 1'b1);
    exp_grant(2, cyc_n + 1); tick();
    beat(2, 32'h100, 3'b010);
    req(0, 1'b1); req(1, 1'b1);
    beat(2, 32'h120, 3'b010);
    beat(2, 32'h140, 3'b010);
    beat(2, 32'h160, 3'b111);
    drop(2);
    m_we[2] = 1'b0;
    exp_grant(0, cyc_n + 1); tick();
    beat(0, 32'h1020, 3'b000); drop(0);
    exp_grant(1, cyc_n + 1); tick();
    beat(1, 32'h2020, 3'b000); drop(1);

    // Watchdog: requester 1 stalls, 0 waits
    req(1, 1'b1);
    t = cyc_n;
    exp_grant(1, t + 1); tick();
    req(0, 1'b1);
    q_err.push_back('{t + 9, 3'b010});
    exp_grant(0, t + 11);
    repeat (10) tick();
    beat(0, 32'h1030, 3'b000); drop(0);
    repeat (3) tick();
    req(1, 1'b0); tick();
    req(1, 1'b1);
    exp_grant(1, cyc_n + 1); tick();
    beat(1, 32'h2030, 3'b000); drop(1);

    // Ack exactly on the threshold cycle, then a shorter stall
    req(1, 1'b1);
    t = cyc_n;
    exp_grant(1, t + 1); tick();
    repeat (8) tick();
    beat(1, 32'h2040, 3'b000);
    repeat (7) tick();
    beat(1, 32'h2080, 3'b000); drop(1);

    // Reset in the middle of a burst
    m_we[2] = 1'b1;
    req(2, 1'b1);
    exp_grant(2, cyc_n + 1); tick();
    beat(2, 32'h200, 3'b010);
    req(0, 1'b1); req(1, 1'b1);
    rst_n = 1'b0;
    cache_ack = 1'b1;
    #1;
    chk_reset("midburst_reset");
    tick();
    cache_ack = 1'b0;
    m_we[2] = 1'b0;
    rst_n = 1'b1;
    exp_grant(0, cyc_n + 1); tick();
    beat(0, 32'h1040, 3'b000);
    req(1, 1'b0); req(2, 1'b0);
    drop(0);

    repeat (3) tick();
    chk("grant_queue_drained", q_grant.size(), 0);
    chk("beat_queue_drained", q_beat.size(), 0);
    chk("err_queue_drained", q_err.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
